// File: rtl/rs_latch_sequencer.sv
// ---------------------------------------------------------------------------
// rs_latch_sequencer
//
// Round-robin controller that shares a bank of NFLAG external RS flip-flops
// between NREQ requesters. Each request asks to set or reset one latch. The
// winner's request becomes a clean S or R pulse of PULSE_CYC clocks. A guard
// of GAP_CYC clocks follows with every S/R line low. The Q read-back is then
// checked and the requester gets a one-cycle ACK. S and R are never high
// together, and at most one latch line is driven at any time.
//
// Optional feature (macro RSSEQ_SKIP_REDUNDANT_EN):
//   When defined, a request whose latch already reads back the requested
//   value is acknowledged straight away (ACK one cycle after the grant).
//   No pulse is driven in that case.
//
// Ports:
//   CLK    in   1        system clock, rising edge
//   RST_B  in   1        asynchronous reset, active low
//   REQ    in   NREQ     request per requester, held high until its ACK
//   CMD    in   NREQ     per requester: 1 = set (S), 0 = reset (R)
//   IDX    in   NREQ*IW  per requester latch index, field i = IDX[i*IW +: IW]
//   ACK    out  NREQ     one-hot, one-cycle completion pulse to the winner
//   S_OUT  out  NFLAG    set drive to the latch bank
//   R_OUT  out  NFLAG    reset drive to the latch bank
//   Q_IN   in   NFLAG    Q read-back from the latch bank
//   BUSY   out  1        high whenever the sequencer is not idle
//   ERR    out  1        sticky: Q mismatch or out-of-range index
// ---------------------------------------------------------------------------
module rs_latch_sequencer #(
    parameter int NREQ      = 4,
    parameter int NFLAG     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1,
    localparam int IW       = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_B,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      CMD,
    input  logic [NREQ*IW-1:0]   IDX,
    output logic [NREQ-1:0]      ACK,
    output logic [NFLAG-1:0]     S_OUT,
    output logic [NFLAG-1:0]     R_OUT,
    input  logic [NFLAG-1:0]     Q_IN,
    output logic                 BUSY,
    output logic                 ERR
);

    localparam int PW   = $clog2(NREQ);
    localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [NFLAG-1:0] FLAG_ONE = {{(NFLAG-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0]  REQ_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GUARD = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [PW-1:0]     win_q, win_d;
    logic              cmd_q, cmd_d;
    logic              valid_q, valid_d;
    logic [NFLAG-1:0]  vec_q, vec_d;
    logic [NFLAG-1:0]  s_q, s_d;
    logic [NFLAG-1:0]  r_q, r_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              found;
    logic [PW-1:0]     win;
    logic [PW-1:0]     cand;
    logic              win_cmd;
    logic [IW-1:0]     win_idx;
    logic              win_valid;
    logic [NFLAG-1:0]  win_vec;
    logic              q_bit;

    // Round-robin arbitration: scan from the requester after the last winner,
    // wrapping at NREQ, and take the first active request.
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        cand  = rr_q;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(rr_q) + i) % NREQ);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Decode the candidate winner's command. An out-of-range index yields an
    // all-zero latch vector, so no pulse can reach the bank for it.
    always_comb begin
        win_cmd   = CMD[win];
        win_idx   = IDX[int'(win)*IW +: IW];
        win_valid = (int'(win_idx) < NFLAG);
        win_vec   = win_valid ? (FLAG_ONE << win_idx) : '0;
    end

    // Read-back of the latch captured at grant; the vector is one-hot or zero.
    assign q_bit = |(Q_IN & vec_q);

    // Next-state and next-output logic. Outputs are decoded from the next
    // state so the registered outputs line up with the registered state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        valid_d = valid_q;
        vec_d   = vec_q;
        s_d     = '0;
        r_d     = '0;
        ack_d   = '0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    rr_d    = win;
                    win_d   = win;
                    cmd_d   = win_cmd;
                    valid_d = win_valid;
                    vec_d   = win_vec;
                    cnt_d   = '0;
                    if (!win_valid) begin
                        err_d = 1'b1;
                    end
`ifdef RSSEQ_SKIP_REDUNDANT_EN
                    if (win_valid && ((|(Q_IN & win_vec)) == win_cmd)) begin
                        state_d = ST_ACK;
                        ack_d   = REQ_ONE << win;
                    end else begin
                        state_d = ST_PULSE;
                        s_d     = win_cmd ? win_vec : '0;
                        r_d     = win_cmd ? '0 : win_vec;
                    end
`else
                    state_d = ST_PULSE;
                    s_d     = win_cmd ? win_vec : '0;
                    r_d     = win_cmd ? '0 : win_vec;
`endif
                end
            end

            ST_PULSE: begin
                if (cnt_q == CW'(PULSE_CYC - 1)) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    s_d   = s_q;
                    r_d   = r_q;
                end
            end

            // The latch has settled by the last guard cycle; compare it then.
            ST_GUARD: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                    ack_d   = REQ_ONE << win_q;
                    if (valid_q && (q_bit != cmd_q)) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. Reset drops S/R immediately and parks the
    // pointer on the last requester so requester 0 has first priority.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= PW'(NREQ - 1);
            win_q   <= '0;
            cmd_q   <= 1'b0;
            valid_q <= 1'b0;
            vec_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            vec_q   <= vec_d;
            s_q     <= s_d;
            r_q     <= r_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign S_OUT = s_q;
    assign R_OUT = r_q;
    assign ACK   = ack_q;
    assign BUSY  = busy_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_rs_latch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rs_latch_sequencer
//
// Bench for rs_latch_sequencer. A main instance (NFLAG=8) drives a modelled
// RS latch bank with per-bit stuck-at masks. A second instance with NFLAG=6
// exercises the out-of-range index path. Expected ACK vectors are queued when
// requests are driven and popped when an ACK appears.
// ---------------------------------------------------------------------------
module tb_rs_latch_sequencer;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IW    = 3;
    localparam int NF6   = 6;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [NREQ-1:0]   req, cmd;
    logic [NREQ*IW-1:0] idx;
    logic [NREQ-1:0]   ack;
    logic [NFLAG-1:0]  s_out, r_out, q_in;
    logic              busy, err;

    logic [NREQ-1:0]   req6, cmd6;
    logic [NREQ*IW-1:0] idx6;
    logic [NREQ-1:0]   ack6;
    logic [NF6-1:0]    s6, r6, q6;
    logic              busy6, err6;

    logic [NFLAG-1:0]  q_lat  = '0;
    logic [NF6-1:0]    q6_lat = '0;
    logic [NFLAG-1:0]  stuck0 = '0;
    logic [NFLAG-1:0]  stuck1 = '0;

    logic [NREQ-1:0]   exp_ack_q [$];
    logic [NFLAG-1:0]  s_hist [0:31];
    logic [NFLAG-1:0]  r_hist [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_latch_sequencer #(.NREQ(NREQ), .NFLAG(NFLAG), .PULSE_CYC(2), .GAP_CYC(1)) u_dut (
        .CLK(clk), .RST_B(rst_b), .REQ(req), .CMD(cmd), .IDX(idx), .ACK(ack),
        .S_OUT(s_out), .R_OUT(r_out), .Q_IN(q_in), .BUSY(busy), .ERR(err)
    );

    rs_latch_sequencer #(.NREQ(NREQ), .NFLAG(NF6), .PULSE_CYC(2), .GAP_CYC(1)) u_dut6 (
        .CLK(clk), .RST_B(rst_b), .REQ(req6), .CMD(cmd6), .IDX(idx6), .ACK(ack6),
        .S_OUT(s6), .R_OUT(r6), .Q_IN(q6), .BUSY(busy6), .ERR(err6)
    );

    // RS latch bank models: set wins over hold, reset clears.
    always @(posedge clk) begin
        q_lat  <= (q_lat | s_out) & ~r_out;
        q6_lat <= (q6_lat | s6) & ~r6;
    end

    assign q_in = (q_lat & ~stuck0) | stuck1;
    assign q6   = q6_lat;

    // S/R exclusivity on the main instance, sampled every falling edge.
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            checks++;
            if (((s_out & r_out) !== '0) || !$onehot0(s_out | r_out)) begin
                errors++;
                $display("[TB] FAIL invariant: S_OUT=%b R_OUT=%b", s_out, r_out);
            end
        end
    end

    // Waits for an ACK on the selected instance, recording S/R per cycle.
    // Cycle k is the clock period after the k-th rising edge since the call.
    task automatic wait_ack(input bit use6, output logic [NREQ-1:0] got, output int cyc);
        got = '0;
        cyc = -1;
        for (int k = 0; k < 32; k++) begin
            s_hist[k] = '0;
            r_hist[k] = '0;
        end
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            s_hist[k] = use6 ? {2'b00, s6} : s_out;
            r_hist[k] = use6 ? {2'b00, r6} : r_out;
            if ((use6 ? ack6 : ack) !== '0) begin
                got = use6 ? ack6 : ack;
                cyc = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req    = '0;
        req6   = '0;
        rst_b  = 1'b0;
        @(negedge clk);
        rst_b  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        req   = 4'($urandom);
        cmd   = 4'($urandom);
        idx   = 12'($urandom);
        req6  = '0;
        cmd6  = '0;
        idx6  = '0;
        #1;
        checks++;
        if ((s_out !== '0) || (r_out !== '0)) begin
            errors++;
            $display("[TB] FAIL reset_sr: S_OUT=%b R_OUT=%b want 0", s_out, r_out);
        end
        checks++;
        if (ack !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ack: got %b want 0000", ack);
        end
        checks++;
        if ((busy !== 1'b0) || (err !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL reset_busy_err: BUSY=%b ERR=%b want 0 0", busy, err);
        end
        @(negedge clk);
        @(negedge clk);
        req   = '0;
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_set();
        logic [NREQ-1:0] got, exp;
        int cyc;
        cmd[1]   = 1'b1;
        idx[5:3] = 3'd5;
        req      = 4'b0010;
        exp_ack_q.push_back(4'b0010);
        wait_ack(1'b0, got, cyc);
        req = '0;
        exp = exp_ack_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL single_ack: got %b want %b", got, exp);
        end
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("[TB] FAIL single_ack_cycle: got %0d want 4", cyc);
        end
        checks++;
        if ((s_hist[1] !== 8'h20) || (s_hist[2] !== 8'h20) || (s_hist[3] !== 8'h00)) begin
            errors++;
            $display("[TB] FAIL single_pulse: S c1=%h c2=%h c3=%h want 20 20 00",
                     s_hist[1], s_hist[2], s_hist[3]);
        end
        checks++;
        if ((r_hist[1] | r_hist[2] | r_hist[3]) !== 8'h00) begin
            errors++;
            $display("[TB] FAIL single_no_r: R seen %h want 00", r_hist[1] | r_hist[2] | r_hist[3]);
        end
        @(negedge clk);
        checks++;
        if ((q_in[5] !== 1'b1) || (err !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL single_q_err: Q5=%b ERR=%b want 1 0", q_in[5], err);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] got, exp;
        int cyc;
        do_reset();
        cmd[0] = 1'b1; idx[2:0] = 3'd1;
        cmd[2] = 1'b0; idx[8:6] = 3'd2;
        req = 4'b0101;
        exp_ack_q.push_back(4'b0001);
        exp_ack_q.push_back(4'b0100);
        for (int n = 0; n < 2; n++) begin
            wait_ack(1'b0, got, cyc);
            req = req & ~got;
            exp = exp_ack_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL rr_first_%0d: got %b want %b", n, got, exp);
            end
        end
        @(negedge clk);
        cmd[3] = 1'b1; idx[11:9] = 3'd7;
        cmd[0] = 1'b0; idx[2:0]  = 3'd0;
        req = 4'b1001;
        exp_ack_q.push_back(4'b1000);
        exp_ack_q.push_back(4'b0001);
        for (int n = 0; n < 2; n++) begin
            wait_ack(1'b0, got, cyc);
            req = req & ~got;
            exp = exp_ack_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL rr_wrap_%0d: got %b want %b", n, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ((q_in[1] !== 1'b1) || (q_in[7] !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL rr_latches: Q1=%b Q7=%b want 1 1", q_in[1], q_in[7]);
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] got, exp;
        int cyc;
        do_reset();
        cmd[0] = 1'b1; idx[2:0] = 3'd4;
        cmd[1] = 1'b0; idx[5:3] = 3'd4;
        req = 4'b0011;
        exp_ack_q.push_back(4'b0001);
        exp_ack_q.push_back(4'b0010);
        for (int n = 0; n < 2; n++) begin
            wait_ack(1'b0, got, cyc);
            req = req & ~got;
            exp = exp_ack_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_order_%0d: got %b want %b", n, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (q_in[4] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_last_wins: Q4=%b want 0", q_in[4]);
        end
    endtask

    task automatic test_fault();
        logic [NREQ-1:0] got, exp;
        int cyc;
        stuck0[3] = 1'b1;
        cmd[0] = 1'b1; idx[2:0] = 3'd3;
        req = 4'b0001;
        exp_ack_q.push_back(4'b0001);
        wait_ack(1'b0, got, cyc);
        req = '0;
        exp = exp_ack_q.pop_front();
        checks++;
        if ((got !== exp) || (cyc != 4)) begin
            errors++;
            $display("[TB] FAIL fault_ack: got %b at cycle %0d want %b at cycle 4", got, cyc, exp);
        end
        checks++;
        if ((s_hist[1] !== 8'h08) || (s_hist[2] !== 8'h08)) begin
            errors++;
            $display("[TB] FAIL fault_pulse: S c1=%h c2=%h want 08 08", s_hist[1], s_hist[2]);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fault_err: ERR=%b want 1", err);
        end
        @(negedge clk);
        cmd[2] = 1'b1; idx[8:6] = 3'd0;
        req = 4'b0100;
        exp_ack_q.push_back(4'b0100);
        wait_ack(1'b0, got, cyc);
        req = '0;
        exp = exp_ack_q.pop_front();
        checks++;
        if ((got !== exp) || (err !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL fault_sticky: ACK=%b ERR=%b want %b 1", got, err, exp);
        end
        stuck0 = '0;
        @(negedge clk);
    endtask

    task automatic test_range();
        logic [NREQ-1:0] got, exp;
        logic [NFLAG-1:0] sr_seen;
        int cyc;
        cmd6[2] = 1'b1; idx6[8:6] = 3'd7;
        req6 = 4'b0100;
        exp_ack_q.push_back(4'b0100);
        wait_ack(1'b1, got, cyc);
        req6 = '0;
        exp = exp_ack_q.pop_front();
        checks++;
        if ((got !== exp) || (cyc != 4)) begin
            errors++;
            $display("[TB] FAIL range_ack: got %b at cycle %0d want %b at cycle 4", got, cyc, exp);
        end
        sr_seen = '0;
        for (int k = 1; k <= 4; k++) sr_seen = sr_seen | s_hist[k] | r_hist[k];
        checks++;
        if (sr_seen !== '0) begin
            errors++;
            $display("[TB] FAIL range_no_pulse: S|R seen %b want 0", sr_seen);
        end
        checks++;
        if (err6 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL range_err: ERR=%b want 1", err6);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        int ack_seen;
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_clears_err: ERR=%b want 0", err);
        end
        cmd[3] = 1'b1; idx[11:9] = 3'd6;
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if (s_out !== 8'h40) begin
            errors++;
            $display("[TB] FAIL midpulse_pre: S_OUT=%h want 40", s_out);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ((s_out !== '0) || (busy !== 1'b0) || (ack !== '0)) begin
            errors++;
            $display("[TB] FAIL midpulse_abort: S_OUT=%h BUSY=%b ACK=%b want 00 0 0000",
                     s_out, busy, ack);
        end
        @(negedge clk);
        req   = '0;
        rst_b = 1'b1;
        ack_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack !== '0) ack_seen++;
        end
        checks++;
        if (ack_seen != 0) begin
            errors++;
            $display("[TB] FAIL midpulse_no_ack: %0d ACK cycles seen want 0", ack_seen);
        end
    endtask

    task automatic test_skip_redundant();
        logic [NREQ-1:0] got, exp;
        int cyc;
        stuck1[3] = 1'b1;
        cmd[1] = 1'b1; idx[5:3] = 3'd3;
        req = 4'b0010;
        exp_ack_q.push_back(4'b0010);
        wait_ack(1'b0, got, cyc);
        req = '0;
        exp = exp_ack_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL skip_ack: got %b want %b", got, exp);
        end
`ifdef RSSEQ_SKIP_REDUNDANT_EN
        checks++;
        if ((cyc != 1) || (s_hist[1] !== 8'h00)) begin
            errors++;
            $display("[TB] FAIL skip_timing: cycle %0d S c1=%h want cycle 1 S 00", cyc, s_hist[1]);
        end
`else
        checks++;
        if ((cyc != 4) || (s_hist[1] !== 8'h08) || (s_hist[2] !== 8'h08)) begin
            errors++;
            $display("[TB] FAIL skip_timing: cycle %0d S c1=%h c2=%h want cycle 4 S 08 08",
                     cyc, s_hist[1], s_hist[2]);
        end
`endif
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skip_err: ERR=%b want 0", err);
        end
        stuck1 = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_round_robin();
        test_back_to_back();
        test_fault();
        test_range();
        test_reset_mid_pulse();
        test_skip_redundant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
